// File: rtl/fio_host_bridge_pkg.sv
// Shared constants and types for the file-I/O host bridge.
// Byte width, idle byte and default FIFO depth live here.
package fio_host_bridge_pkg;

    localparam int FIO_BYTE_W = 8;
    localparam int FIO_ADDR_W = 3;
    localparam logic [FIO_BYTE_W-1:0] FIO_IDLE_BYTE = 8'hff;

    typedef logic [FIO_BYTE_W-1:0] fio_byte_t;

endpackage

// File: rtl/fio_sync_fifo.sv
// Synchronous byte FIFO with wrap-bit pointers.
// Head is read from registered state; level is wptr - rptr.
module fio_sync_fifo
    import fio_host_bridge_pkg::*;
#(
    parameter int ADDR_W = FIO_ADDR_W
) (
    input  logic            mclk,
    input  logic            puc_rst,
    input  logic            push,
    input  fio_byte_t       wdata,
    input  logic            pop,
    output logic            full,
    output logic            empty,
    output logic [ADDR_W:0] level,
    output fio_byte_t       head
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] PTR_ONE = 1;

    fio_byte_t       mem [DEPTH];
    logic [ADDR_W:0] wptr;
    logic [ADDR_W:0] rptr;
    logic            pop_ok;
    logic            push_ok;

    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    assign empty = (wptr == rptr);
    assign full  = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                   (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
    assign level = wptr - rptr;
    assign head  = mem[rptr[ADDR_W-1:0]];

    // Pointer update; reset discards all buffered bytes.
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) wptr <= wptr + PTR_ONE;
            if (pop_ok)  rptr <= rptr + PTR_ONE;
        end
    end

    // Storage array; contents are don't-care until pointers cover them.
    always_ff @(posedge mclk) begin
        if (push_ok) mem[wptr[ADDR_W-1:0]] <= wdata;
    end

endmodule

// File: rtl/fio_host_bridge.sv
// Host-side endpoint of the file-I/O byte interface.
// RX FIFO feeds the peripheral, TX FIFO captures CPU bytes.
module fio_host_bridge
    import fio_host_bridge_pkg::*;
#(
    parameter int        ADDR_W    = FIO_ADDR_W,
    parameter fio_byte_t IDLE_BYTE = FIO_IDLE_BYTE
) (
    input  logic            mclk,
    input  logic            puc_rst,
    output fio_byte_t       fio_din,
    output logic            fio_dready,
    input  logic            fio_dnxt,
    input  fio_byte_t       fio_dout,
    input  logic            fio_dout_rdy,
    input  fio_byte_t       host_in_data,
    input  logic            host_in_valid,
    output logic            host_in_ready,
    output fio_byte_t       host_out_data,
    output logic            host_out_valid,
    input  logic            host_out_ready,
    output logic [ADDR_W:0] rx_level,
    output logic [ADDR_W:0] tx_level,
    output logic            tx_ovf,
    input  logic            ovf_clr
);

    logic      dnxt_q;
    logic      dnxt_rise;
    logic      rx_full;
    logic      rx_empty;
    logic      rx_push;
    logic      rx_pop;
    fio_byte_t rx_head;
    logic      tx_full;
    logic      tx_empty;
    logic      tx_push;
    logic      tx_pop;
    logic      tx_drop;
    fio_byte_t tx_head;

    // RX ready looks only at stored occupancy, never at a same-cycle pop.
    assign host_in_ready = ~rx_full;
    assign rx_push       = host_in_valid & ~rx_full;
    assign dnxt_rise     = fio_dnxt & ~dnxt_q;
    assign rx_pop        = dnxt_rise & ~rx_empty;

    assign fio_dready = ~rx_empty;
    assign fio_din    = rx_empty ? IDLE_BYTE : rx_head;

    // The CPU cannot be stalled: a full TX either makes room or drops.
    assign tx_pop  = ~tx_empty & host_out_ready;
    assign tx_push = fio_dout_rdy & (~tx_full | tx_pop);
    assign tx_drop = fio_dout_rdy & tx_full & ~host_out_ready;

    assign host_out_valid = ~tx_empty;
    assign host_out_data  = tx_empty ? '0 : tx_head;

    // fio_dnxt edge detector: one pop per read strobe however long it is held.
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) dnxt_q <= 1'b0;
        else         dnxt_q <= fio_dnxt;
    end

    // Sticky overflow flag; a drop in the same cycle wins over a clear.
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst)      tx_ovf <= 1'b0;
        else if (tx_drop) tx_ovf <= 1'b1;
        else if (ovf_clr) tx_ovf <= 1'b0;
    end

    fio_sync_fifo #(
        .ADDR_W (ADDR_W)
    ) u_rx_fifo (
        .mclk    (mclk),
        .puc_rst (puc_rst),
        .push    (rx_push),
        .wdata   (host_in_data),
        .pop     (rx_pop),
        .full    (rx_full),
        .empty   (rx_empty),
        .level   (rx_level),
        .head    (rx_head)
    );

    fio_sync_fifo #(
        .ADDR_W (ADDR_W)
    ) u_tx_fifo (
        .mclk    (mclk),
        .puc_rst (puc_rst),
        .push    (tx_push),
        .wdata   (fio_dout),
        .pop     (tx_pop),
        .full    (tx_full),
        .empty   (tx_empty),
        .level   (tx_level),
        .head    (tx_head)
    );

endmodule

// File: tb/tb_fio_host_bridge.sv
// Scoreboard bench for fio_host_bridge.
// Stimulus queues expected bytes; a negedge monitor pops and compares.
module tb_fio_host_bridge;
    import fio_host_bridge_pkg::*;

    logic       mclk = 1'b0;
    logic       puc_rst = 1'b1;
    logic [7:0] fio_din;
    logic       fio_dready;
    logic       fio_dnxt = 1'b0;
    logic [7:0] fio_dout = 8'h00;
    logic       fio_dout_rdy = 1'b0;
    logic [7:0] host_in_data = 8'h00;
    logic       host_in_valid = 1'b0;
    logic       host_in_ready;
    logic [7:0] host_out_data;
    logic       host_out_valid;
    logic       host_out_ready = 1'b0;
    logic [3:0] rx_level;
    logic [3:0] tx_level;
    logic       tx_ovf;
    logic       ovf_clr = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [7:0] rx_exp[$];
    logic [7:0] tx_exp[$];
    logic mon_dnxt_q = 1'b0;

    fio_host_bridge dut (
        .mclk           (mclk),
        .puc_rst        (puc_rst),
        .fio_din        (fio_din),
        .fio_dready     (fio_dready),
        .fio_dnxt       (fio_dnxt),
        .fio_dout       (fio_dout),
        .fio_dout_rdy   (fio_dout_rdy),
        .host_in_data   (host_in_data),
        .host_in_valid  (host_in_valid),
        .host_in_ready  (host_in_ready),
        .host_out_data  (host_out_data),
        .host_out_valid (host_out_valid),
        .host_out_ready (host_out_ready),
        .rx_level       (rx_level),
        .tx_level       (tx_level),
        .tx_ovf         (tx_ovf),
        .ovf_clr        (ovf_clr)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    // Monitor: an RX read strobe or a TX handshake consumes the next expected byte.
    always @(negedge mclk) begin
        if (puc_rst) begin
            mon_dnxt_q = 1'b0;
        end else begin
            if (fio_dnxt && !mon_dnxt_q && fio_dready) begin
                if (rx_exp.size() == 0) chk("rx_unexpected", 32'(fio_din), 'h1ff);
                else chk("rx_byte", 32'(fio_din), 32'(rx_exp.pop_front()));
            end
            mon_dnxt_q = fio_dnxt;
            if (host_out_valid && host_out_ready) begin
                if (tx_exp.size() == 0) chk("tx_unexpected", 32'(host_out_data), 'h1ff);
                else chk("tx_byte", 32'(host_out_data), 32'(tx_exp.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge mclk);
        @(negedge mclk);
        chk("rst_din", 32'(fio_din), 'hff);
        chk("rst_dready", 32'(fio_dready), 0);
        chk("rst_in_ready", 32'(host_in_ready), 1);
        chk("rst_out_valid", 32'(host_out_valid), 0);
        chk("rst_out_data", 32'(host_out_data), 0);
        chk("rst_rx_level", 32'(rx_level), 0);
        chk("rst_tx_level", 32'(tx_level), 0);
        chk("rst_ovf", 32'(tx_ovf), 0);
        step();
        puc_rst = 1'b0;

        // Single RX byte, visible the cycle after the push.
        host_in_data = 8'h41; host_in_valid = 1'b1; rx_exp.push_back(8'h41);
        step();
        host_in_valid = 1'b0;
        @(negedge mclk);
        chk("t1_dready", 32'(fio_dready), 1);
        chk("t1_din", 32'(fio_din), 'h41);
        chk("t1_level", 32'(rx_level), 1);
        step();
        fio_dnxt = 1'b1;
        step();
        fio_dnxt = 1'b0;
        @(negedge mclk);
        chk("t1_level_pop", 32'(rx_level), 0);
        chk("t1_din_idle", 32'(fio_din), 'hff);

        // Fill RX, hold a 9th byte, long dnxt pulse pops once.
        step();
        for (int i = 0; i < 8; i++) begin
            host_in_data = 8'(i); host_in_valid = 1'b1; rx_exp.push_back(8'(i));
            step();
        end
        host_in_data = 8'h08;
        @(negedge mclk);
        chk("t2_ready_full", 32'(host_in_ready), 0);
        chk("t2_level_full", 32'(rx_level), 8);
        step();
        @(negedge mclk);
        chk("t2_level_held", 32'(rx_level), 8);
        step();
        fio_dnxt = 1'b1;
        step();
        @(negedge mclk);
        chk("t2_din_next", 32'(fio_din), 'h01);
        chk("t2_level_pop", 32'(rx_level), 7);
        chk("t2_ready_pop", 32'(host_in_ready), 1);
        rx_exp.push_back(8'h08);
        step();
        host_in_valid = 1'b0;
        step();
        fio_dnxt = 1'b0;
        @(negedge mclk);
        chk("t2_level_once", 32'(rx_level), 8);
        step();
        repeat (8) begin
            fio_dnxt = 1'b1; step();
            fio_dnxt = 1'b0; step();
        end
        @(negedge mclk);
        chk("t2_level_drained", 32'(rx_level), 0);

        // Reads on empty RX are ignored.
        step();
        repeat (2) begin
            fio_dnxt = 1'b1; step();
            fio_dnxt = 1'b0; step();
        end
        @(negedge mclk);
        chk("t3_din_idle", 32'(fio_din), 'hff);
        chk("t3_level", 32'(rx_level), 0);
        chk("t3_ready", 32'(host_in_ready), 1);
        step();
        host_in_data = 8'h5a; host_in_valid = 1'b1; rx_exp.push_back(8'h5a);
        step();
        host_in_valid = 1'b0;
        @(negedge mclk);
        chk("t3_din_ptr", 32'(fio_din), 'h5a);
        chk("t3_level_one", 32'(rx_level), 1);
        step();
        host_in_data = 8'h6b; host_in_valid = 1'b1; fio_dnxt = 1'b1;
        rx_exp.push_back(8'h6b);
        step();
        host_in_valid = 1'b0; fio_dnxt = 1'b0;
        @(negedge mclk);
        chk("t3_pushpop_level", 32'(rx_level), 1);
        chk("t3_pushpop_din", 32'(fio_din), 'h6b);
        step();
        fio_dnxt = 1'b1; step();
        fio_dnxt = 1'b0;
        @(negedge mclk);
        chk("t3_level_end", 32'(rx_level), 0);

        // Fill TX with the harness stalled, then overflow.
        step();
        host_out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            fio_dout = 8'('h10 + i); fio_dout_rdy = 1'b1;
            tx_exp.push_back(8'('h10 + i));
            step();
        end
        fio_dout_rdy = 1'b0;
        @(negedge mclk);
        chk("t4_tx_level", 32'(tx_level), 8);
        chk("t4_out_valid", 32'(host_out_valid), 1);
        chk("t4_out_data", 32'(host_out_data), 'h10);
        chk("t4_ovf_clear", 32'(tx_ovf), 0);
        step();
        fio_dout = 8'h18; fio_dout_rdy = 1'b1;
        step();
        fio_dout_rdy = 1'b0;
        @(negedge mclk);
        chk("t4_ovf_set", 32'(tx_ovf), 1);
        chk("t4_level_drop", 32'(tx_level), 8);
        chk("t4_data_stable", 32'(host_out_data), 'h10);

        // Full TX with ready: pop and push together, no drop.
        step();
        fio_dout = 8'h20; fio_dout_rdy = 1'b1; host_out_ready = 1'b1;
        tx_exp.push_back(8'h20);
        step();
        fio_dout_rdy = 1'b0; host_out_ready = 1'b0;
        @(negedge mclk);
        chk("t5_level", 32'(tx_level), 8);
        chk("t5_ovf", 32'(tx_ovf), 1);
        chk("t5_head", 32'(host_out_data), 'h11);

        // Set beats clear, then a plain clear.
        step();
        fio_dout = 8'h30; fio_dout_rdy = 1'b1; ovf_clr = 1'b1;
        step();
        fio_dout_rdy = 1'b0;
        @(negedge mclk);
        chk("t5_set_wins", 32'(tx_ovf), 1);
        chk("t5_level_drop", 32'(tx_level), 8);
        step();
        ovf_clr = 1'b0;
        @(negedge mclk);
        chk("t5_ovf_cleared", 32'(tx_ovf), 0);
        step();
        host_out_ready = 1'b1;
        repeat (4) step();
        host_out_ready = 1'b0;
        @(negedge mclk);
        chk("t5_level_drain", 32'(tx_level), 4);
        chk("t5_head_drain", 32'(host_out_data), 'h15);

        // Reset with both FIFOs holding data.
        step();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                host_in_data = 8'('ha1 + i); host_in_valid = 1'b1;
                rx_exp.push_back(8'('ha1 + i));
                tx_exp.push_back(8'('h40 + i));
            end else begin
                host_in_valid = 1'b0;
            end
            fio_dout = 8'('h40 + i); fio_dout_rdy = 1'b1;
            step();
        end
        host_in_valid = 1'b0; fio_dout_rdy = 1'b0;
        @(negedge mclk);
        chk("t6_rx_level", 32'(rx_level), 4);
        chk("t6_tx_level", 32'(tx_level), 8);
        chk("t6_ovf", 32'(tx_ovf), 1);
        #2;
        puc_rst = 1'b1;
        #1;
        chk("t6_rst_rx_level", 32'(rx_level), 0);
        chk("t6_rst_tx_level", 32'(tx_level), 0);
        chk("t6_rst_dready", 32'(fio_dready), 0);
        chk("t6_rst_out_valid", 32'(host_out_valid), 0);
        chk("t6_rst_ovf", 32'(tx_ovf), 0);
        chk("t6_rst_din", 32'(fio_din), 'hff);
        rx_exp.delete();
        tx_exp.delete();
        step();
        puc_rst = 1'b0;

        // Traffic after reset.
        step();
        host_in_data = 8'hc3; host_in_valid = 1'b1; rx_exp.push_back(8'hc3);
        fio_dout = 8'h55; fio_dout_rdy = 1'b1; tx_exp.push_back(8'h55);
        step();
        host_in_valid = 1'b0; fio_dout_rdy = 1'b0;
        @(negedge mclk);
        chk("t7_din", 32'(fio_din), 'hc3);
        chk("t7_out_data", 32'(host_out_data), 'h55);
        step();
        host_out_ready = 1'b1; fio_dnxt = 1'b1;
        step();
        host_out_ready = 1'b0; fio_dnxt = 1'b0;
        step();
        @(negedge mclk);
        chk("t7_rx_level", 32'(rx_level), 0);
        chk("t7_tx_level", 32'(tx_level), 0);
        chk("rx_queue_empty", 32'(rx_exp.size()), 0);
        chk("tx_queue_empty", 32'(tx_exp.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
